// File: rtl/motor_cmd_sequencer_if.sv
// Command handshake between the SPI register block and one motor sequencer.
interface motor_cmd_sequencer_if #(
    parameter int unsigned DUTY_WIDTH = 10
) ();
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [DUTY_WIDTH-1:0] cmd_duty;
    logic                  cmd_dir;

    modport master (
        output cmd_valid,
        output cmd_duty,
        output cmd_dir,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_duty,
        input  cmd_dir,
        output cmd_ready
    );
endinterface

// File: rtl/motor_cmd_sequencer.sv
// Per-motor command sequencer: slew-limited duty, reversal via ramp-down and
// dead-time coast, fault off-time with auto-retry and latched lockout.
module motor_cmd_sequencer #(
    parameter int unsigned DUTY_WIDTH  = 10,
    parameter int unsigned RAMP_STEP   = 8,
    parameter int unsigned RAMP_DIV    = 64,
    parameter int unsigned DEADTIME    = 256,
    parameter int unsigned RETRY_WAIT  = 4096,
    parameter int unsigned MAX_RETRIES = 3
) (
    input  logic                  clock,
    input  logic                  reset_n,
    motor_cmd_sequencer_if.slave  cmd,
    input  logic                  clear_fault,
    input  logic                  drv_fault,
    output logic [DUTY_WIDTH-1:0] duty_cycle,
    output logic                  dir,
    output logic                  drive_en,
    output logic [2:0]            state,
    output logic [1:0]            retry_count,
    output logic                  lockout
);
    localparam int unsigned PW   = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int unsigned WMAX = (DEADTIME > RETRY_WAIT) ? DEADTIME : RETRY_WAIT;
    localparam int unsigned WW   = (WMAX > 1) ? $clog2(WMAX) : 1;
    localparam logic [DUTY_WIDTH-1:0] STEP = DUTY_WIDTH'(RAMP_STEP);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_RUN        = 3'd1,
        S_COAST      = 3'd2,
        S_FAULT_WAIT = 3'd3,
        S_LOCKOUT    = 3'd4
    } state_t;

    state_t                state_q;
    logic [DUTY_WIDTH-1:0] target_duty;
    logic                  target_dir;
    logic [PW-1:0]         prescale;
    logic [WW-1:0]         wait_cnt;

    logic                  accept;
    logic                  tick;
    logic                  coast_done;
    logic                  retry_done;
    logic                  fault_hit;
    logic [DUTY_WIDTH-1:0] eff_target;
    logic [DUTY_WIDTH-1:0] diff;
    logic [DUTY_WIDTH-1:0] ramp_next;

    assign cmd.cmd_ready = ((state_q == S_IDLE) || (state_q == S_RUN)) && !drv_fault;
    assign state         = state_q;

    // Event decode and the next slew-limited duty value.
    always_comb begin
        accept     = cmd.cmd_valid && cmd.cmd_ready;
        tick       = (prescale == PW'(RAMP_DIV - 1));
        coast_done = (wait_cnt == WW'(DEADTIME - 1));
        retry_done = (wait_cnt == WW'(RETRY_WAIT - 1));
        fault_hit  = drv_fault && ((state_q == S_IDLE) || (state_q == S_RUN) ||
                                   (state_q == S_COAST) ||
                                   ((state_q == S_FAULT_WAIT) && retry_done));
        eff_target = (target_dir == dir) ? target_duty : '0;
        diff       = '0;
        ramp_next  = duty_cycle;
        if (eff_target > duty_cycle) begin
            diff      = eff_target - duty_cycle;
            ramp_next = (diff > STEP) ? (duty_cycle + STEP) : eff_target;
        end else begin
            diff      = duty_cycle - eff_target;
            ramp_next = (diff > STEP) ? (duty_cycle - STEP) : eff_target;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            duty_cycle  <= '0;
            dir         <= 1'b0;
            drive_en    <= 1'b0;
            retry_count <= '0;
            lockout     <= 1'b0;
            target_duty <= '0;
            target_dir  <= 1'b0;
            prescale    <= '0;
            wait_cnt    <= '0;
        end else begin
            if (accept) begin
                target_duty <= cmd.cmd_duty;
                target_dir  <= cmd.cmd_dir;
            end
            if (clear_fault && (state_q != S_LOCKOUT)) begin
                retry_count <= '0;
            end

            // A fault pre-empts every other transition in the cycle it lands.
            if (fault_hit) begin
                duty_cycle <= '0;
                drive_en   <= 1'b0;
                wait_cnt   <= '0;
                if (retry_count < 2'(MAX_RETRIES)) begin
                    retry_count <= retry_count + 2'd1;
                    state_q     <= S_FAULT_WAIT;
                end else begin
                    lockout <= 1'b1;
                    state_q <= S_LOCKOUT;
                end
            end else begin
                case (state_q)
                    S_IDLE: begin
                        duty_cycle <= '0;
                        drive_en   <= 1'b0;
                        if (target_duty != '0) begin
                            dir      <= target_dir;
                            prescale <= '0;
                            drive_en <= 1'b1;
                            state_q  <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        prescale <= tick ? '0 : (prescale + PW'(1));
                        if ((duty_cycle == '0) && (target_dir != dir)) begin
                            drive_en <= 1'b0;
                            wait_cnt <= '0;
                            state_q  <= S_COAST;
                        end else if ((duty_cycle == '0) && (target_duty == '0)) begin
                            drive_en    <= 1'b0;
                            retry_count <= '0;
                            state_q     <= S_IDLE;
                        end else begin
                            drive_en <= 1'b1;
                            if (tick) begin
                                duty_cycle <= ramp_next;
                            end
                        end
                    end
                    S_COAST: begin
                        duty_cycle <= '0;
                        drive_en   <= 1'b0;
                        wait_cnt   <= wait_cnt + WW'(1);
                        if (coast_done) begin
                            dir      <= target_dir;
                            wait_cnt <= '0;
                            if (target_duty != '0) begin
                                prescale <= '0;
                                drive_en <= 1'b1;
                                state_q  <= S_RUN;
                            end else begin
                                state_q <= S_IDLE;
                            end
                        end
                    end
                    S_FAULT_WAIT: begin
                        drive_en <= 1'b0;
                        wait_cnt <= wait_cnt + WW'(1);
                        if (retry_done) begin
                            duty_cycle <= '0;
                            prescale   <= '0;
                            wait_cnt   <= '0;
                            drive_en   <= 1'b1;
                            state_q    <= S_RUN;
                        end
                    end
                    S_LOCKOUT: begin
                        duty_cycle <= '0;
                        drive_en   <= 1'b0;
                        if (clear_fault) begin
                            lockout     <= 1'b0;
                            retry_count <= '0;
                            target_duty <= '0;
                            state_q     <= S_IDLE;
                        end
                    end
                    default: begin
                        duty_cycle <= '0;
                        drive_en   <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_motor_cmd_sequencer.sv
// Directed bench for motor_cmd_sequencer: event-timed behavioural model checked
// every cycle, plus hand-computed checkpoints along the scenario.
module tb_motor_cmd_sequencer;
    localparam int DW    = 10;
    localparam int STEP  = 8;
    localparam int RD    = 64;
    localparam int DT    = 256;
    localparam int RW    = 4096;
    localparam int MAXR  = 3;

    logic          clock;
    logic          reset_n;
    logic          clear_fault;
    logic          drv_fault;
    logic [DW-1:0] duty_cycle;
    logic          dir;
    logic          drive_en;
    logic [2:0]    state;
    logic [1:0]    retry_count;
    logic          lockout;

    motor_cmd_sequencer_if #(.DUTY_WIDTH(DW)) cmd_if ();

    motor_cmd_sequencer #(
        .DUTY_WIDTH(DW), .RAMP_STEP(STEP), .RAMP_DIV(RD),
        .DEADTIME(DT), .RETRY_WAIT(RW), .MAX_RETRIES(MAXR)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .cmd(cmd_if),
        .clear_fault(clear_fault),
        .drv_fault(drv_fault),
        .duty_cycle(duty_cycle),
        .dir(dir),
        .drive_en(drive_en),
        .state(state),
        .retry_count(retry_count),
        .lockout(lockout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests  = 0;
    int failed = 0;
    bit chk_on = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: modes use the published encoding; ticks derive from the cycle
    // distance to RUN entry, waits from an absolute wake-up cycle.
    int m_mode, m_duty, m_dir, m_en, m_rc, m_lock, m_tduty, m_tdir;
    int origin, wake, cyc, old_rc, goal;
    bit rdy, acc, flt;

    initial begin
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) begin
                m_mode = 0; m_duty = 0; m_dir = 0; m_en = 0; m_rc = 0; m_lock = 0;
                m_tduty = 0; m_tdir = 0; origin = 0; wake = 0;
            end else begin
                cyc++;
                rdy    = (m_mode <= 1) && !drv_fault;
                acc    = cmd_if.cmd_valid && rdy;
                old_rc = m_rc;
                flt    = drv_fault && ((m_mode <= 2) || (m_mode == 3 && cyc == wake));
                if (clear_fault && m_mode != 4) m_rc = 0;
                if (flt) begin
                    m_duty = 0;
                    m_en   = 0;
                    if (old_rc < MAXR) begin
                        m_rc = old_rc + 1; m_mode = 3; wake = cyc + RW;
                    end else begin
                        m_lock = 1; m_mode = 4;
                    end
                end else begin
                    case (m_mode)
                        0: if (m_tduty != 0) begin
                               m_dir = m_tdir; m_mode = 1; origin = cyc; m_en = 1;
                           end
                        1: begin
                            if (m_duty == 0 && m_tdir != m_dir) begin
                                m_mode = 2; m_en = 0; wake = cyc + DT;
                            end else if (m_duty == 0 && m_tduty == 0) begin
                                m_mode = 0; m_en = 0; m_rc = 0;
                            end else if ((cyc - origin) % RD == 0) begin
                                goal = (m_tdir == m_dir) ? m_tduty : 0;
                                if (goal > m_duty)
                                    m_duty = (m_duty + STEP < goal) ? m_duty + STEP : goal;
                                else
                                    m_duty = (m_duty - STEP > goal) ? m_duty - STEP : goal;
                            end
                        end
                        2: if (cyc == wake) begin
                               m_dir = m_tdir;
                               if (m_tduty != 0) begin
                                   m_mode = 1; origin = cyc; m_en = 1;
                               end else begin
                                   m_mode = 0;
                               end
                           end
                        3: if (cyc == wake) begin
                               m_mode = 1; m_duty = 0; origin = cyc; m_en = 1;
                           end
                        default: if (clear_fault) begin
                               m_mode = 0; m_lock = 0; m_rc = 0; m_tduty = 0;
                           end
                    endcase
                end
                if (acc) begin
                    m_tduty = int'(cmd_if.cmd_duty);
                    m_tdir  = int'(cmd_if.cmd_dir);
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        if (reset_n && chk_on) begin
            check("duty_cycle", int'(duty_cycle), m_duty);
            check("dir", int'(dir), m_dir);
            check("drive_en", int'(drive_en), m_en);
            check("state", int'(state), m_mode);
            check("retry_count", int'(retry_count), m_rc);
            check("lockout", int'(lockout), m_lock);
            check("cmd_ready", int'(cmd_if.cmd_ready), int'((m_mode <= 1) && !drv_fault));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send(input int d, input int r);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_duty  = DW'(d);
        cmd_if.cmd_dir   = r[0];
        step(1);
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_state(input int s, input int budget, input string name);
        int n;
        n = 0;
        while (int'(state) != s && n < budget) begin
            step(1);
            n++;
        end
        check(name, int'(state), s);
    endtask

    int c;

    initial begin
        reset_n          = 1'b0;
        clear_fault      = 1'b0;
        drv_fault        = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_duty  = '0;
        cmd_if.cmd_dir   = 1'b0;
        step(3);
        check("rst_state", int'(state), 0);
        check("rst_duty", int'(duty_cycle), 0);
        check("rst_drive_en", int'(drive_en), 0);
        check("rst_lockout", int'(lockout), 0);
        reset_n = 1'b1;
        chk_on  = 1'b1;
        step(2);

        // Ramp up from rest to 200 in direction 1.
        send(200, 1);
        step(1);
        check("run_entry_state", int'(state), 1);
        check("run_entry_en", int'(drive_en), 1);
        check("run_entry_dir", int'(dir), 1);
        step(1599);
        check("ramp_24_ticks", int'(duty_cycle), 192);
        step(1);
        check("ramp_25_ticks", int'(duty_cycle), 200);
        step(200);
        check("ramp_hold", int'(duty_cycle), 200);

        // Reversal: ramp down, coast for the dead-time, then ramp up the other way.
        send(100, 0);
        wait_state(2, 3000, "reach_coast");
        check("coast_duty", int'(duty_cycle), 0);
        check("coast_en", int'(drive_en), 0);
        check("coast_ready", int'(cmd_if.cmd_ready), 0);
        send(500, 1);
        c = 1;
        while (int'(state) == 2 && c < 400) begin
            step(1);
            c++;
        end
        check("coast_len", c, DT);
        check("post_coast_state", int'(state), 1);
        check("post_coast_dir", int'(dir), 0);
        step(768);
        check("rev_ramp_12", int'(duty_cycle), 96);
        step(64);
        check("rev_ramp_13", int'(duty_cycle), 100);

        // Command to zero returns to idle.
        send(0, 0);
        wait_state(0, 2000, "ramp_to_idle");
        check("idle_en", int'(drive_en), 0);
        check("idle_rc", int'(retry_count), 0);

        // Single-cycle fault in RUN and timed recovery.
        send(300, 1);
        step(100);
        drv_fault = 1'b1;
        #1;
        check("fault_ready", int'(cmd_if.cmd_ready), 0);
        step(1);
        drv_fault = 1'b0;
        check("fault_state", int'(state), 3);
        check("fault_rc", int'(retry_count), 1);
        check("fault_duty", int'(duty_cycle), 0);
        check("fault_en", int'(drive_en), 0);
        step(RW - 1);
        check("fault_wait_hold", int'(state), 3);
        step(1);
        check("retry_state", int'(state), 1);
        check("retry_duty", int'(duty_cycle), 0);
        step(64);
        check("retry_first_tick", int'(duty_cycle), 8);

        // Command and fault in the same cycle: the command is dropped.
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_duty  = DW'(50);
        cmd_if.cmd_dir   = 1'b1;
        drv_fault        = 1'b1;
        step(1);
        cmd_if.cmd_valid = 1'b0;
        drv_fault        = 1'b0;
        check("cofault_state", int'(state), 3);
        check("cofault_rc", int'(retry_count), 2);
        step(RW);
        check("cofault_recover", int'(state), 1);
        step(448);
        check("cofault_target_kept", int'(duty_cycle), 56);

        // Clear in RUN only resets the retry count; a held fault then locks out.
        clear_fault = 1'b1;
        step(1);
        clear_fault = 1'b0;
        check("clear_rc", int'(retry_count), 0);
        check("clear_state", int'(state), 1);
        drv_fault = 1'b1;
        step(1);
        check("hold_rc1", int'(retry_count), 1);
        step(RW);
        check("hold_rc2", int'(retry_count), 2);
        step(RW);
        check("hold_rc3", int'(retry_count), 3);
        check("hold_rc3_state", int'(state), 3);
        step(RW);
        check("lockout_state", int'(state), 4);
        check("lockout_flag", int'(lockout), 1);
        drv_fault = 1'b0;
        step(2);
        check("lockout_ready", int'(cmd_if.cmd_ready), 0);
        send(200, 1);
        step(2);
        check("lockout_cmd_dropped", int'(state), 4);
        clear_fault = 1'b1;
        step(1);
        clear_fault = 1'b0;
        check("unlock_state", int'(state), 0);
        check("unlock_flag", int'(lockout), 0);
        check("unlock_rc", int'(retry_count), 0);
        step(5);
        check("unlock_target_zero", int'(state), 0);

        // Asynchronous reset mid-ramp.
        send(400, 1);
        step(201);
        check("pre_reset_duty", int'(duty_cycle), 24);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_duty", int'(duty_cycle), 0);
        check("async_state", int'(state), 0);
        check("async_en", int'(drive_en), 0);
        check("async_dir", int'(dir), 0);
        step(2);
        reset_n = 1'b1;
        step(5);
        check("post_reset_idle", int'(state), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/motor_cmd_sequencer.md
Name: motor_cmd_sequencer

Overview:
- Per-motor command sequencer between the SPI-loaded motor command registers and one Motor_Driver instance.
- Accepts duty and direction commands and slew-limits duty changes.
- On a direction reversal, ramps the motor down to zero, then coasts for a dead-time before flipping direction.
- Handles driver faults with timed auto-retry, followed by latched lockout.

Parameters:
- DUTY_WIDTH, 10, width of the duty command and output.
- RAMP_STEP, 8, maximum duty change per ramp tick.
- RAMP_DIV, 64, clock cycles between ramp ticks.
- DEADTIME, 256, coast cycles before a direction flip.
- RETRY_WAIT, 4096, off-time cycles after a fault.
- MAX_RETRIES, 3, auto-retries before lockout (1..3).

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command strobe
- cmd_ready  out  1  command accept
- cmd_duty  in  DUTY_WIDTH  target duty
- cmd_dir  in  1  target direction
- clear_fault  in  1  single-cycle clear pulse
- drv_fault  in  1  driver fault, synchronous to clock
- duty_cycle  out  DUTY_WIDTH  to Motor_Driver duty input
- dir  out  1  to Motor_Driver direction input
- drive_en  out  1  gates Motor_Driver phase outputs
- state  out  3  current state encoding
- retry_count  out  2  faults consumed
- lockout  out  1  latched lockout flag

Behaviour:
- Reset (async, reset_n=0):
  - duty_cycle=0, dir=0, drive_en=0, state=IDLE, retry_count=0, lockout=0.
  - target_duty=0, target_dir=0, all counters 0.
- State encodings: IDLE=0, RUN=1, COAST=2, FAULT_WAIT=3, LOCKOUT=4.
- cmd_ready is combinational: (state==IDLE or state==RUN) and !drv_fault.
  - On cmd_valid&cmd_ready at an edge, target_duty and target_dir load. No other effect in that cycle.
  - A command presented while cmd_ready=0 is dropped, not queued.
- Fault priority: drv_fault=1 in IDLE/RUN/COAST overrides all other transitions that cycle.
  - Next cycle: duty_cycle=0, drive_en=0.
  - If retry_count<MAX_RETRIES: retry_count+1 and go to FAULT_WAIT.
  - Otherwise: lockout=1 and go to LOCKOUT.
- IDLE:
  - drive_en=0, duty_cycle=0.
  - If target_duty!=0: dir<=target_dir, go to RUN, ramp prescaler cleared.
  - A command accepted at edge N gives state=RUN at edge N+1.
- RUN:
  - drive_en=1.
  - The prescaler counts 0..RAMP_DIV-1; a tick occurs at RAMP_DIV-1. The first tick is RAMP_DIV cycles after entering RUN.
  - eff_target = target_duty when target_dir==dir, else 0.
  - On a tick, duty_cycle moves toward eff_target by min(RAMP_STEP, |diff|), never overshooting. Arithmetic is unsigned, no wrap; clamp at 0 and at the target.
  - A new command mid-ramp retargets immediately. The prescaler is not reset.
  - Exit to COAST when duty_cycle==0 and target_dir!=dir; drive_en=0 from the next cycle.
  - Exit to IDLE when duty_cycle==0 and target_duty==0 and directions match; retry_count clears.
- COAST:
  - drive_en=0, duty_cycle=0. Counts DEADTIME cycles.
  - At expiry: dir<=target_dir, then go to RUN if target_duty!=0, else IDLE.
  - Commands are held off during COAST.
- FAULT_WAIT:
  - drive_en=0. Counts RETRY_WAIT cycles; drv_fault is ignored during the count.
  - At expiry, with drv_fault=0: go to RUN with duty_cycle=0 and dir unchanged, then ramp to the stored target.
  - At expiry, with drv_fault=1: treat as a new fault (increment or lockout, as above).
- LOCKOUT:
  - drive_en=0, duty_cycle=0, cmd_ready=0.
  - Exit only on clear_fault: next state IDLE, lockout=0, retry_count=0, target_duty=0.
- clear_fault in any other state clears retry_count only.
- Reset asserted mid-ramp or mid-wait forces reset values immediately, with no clock edge required.

Test Plan:
- From reset, cmd(duty=200, dir=1) → RUN next edge, drive_en=1; duty steps +8 every 64 cycles; reaches 200 after 25 ticks (1600 cycles) and holds.
- At duty=200/dir=1, cmd(duty=100, dir=0):
  - Duty falls by 8 per tick to 0 (25 ticks), then COAST: drive_en=0 for 256 cycles.
  - dir flips to 0, then ramps up to 100 (13 ticks, last step +4).
- At duty=100, cmd(duty=0, dir=same) → duty ramps to 0, state returns to IDLE, drive_en=0, retry_count=0.
- In RUN, pulse drv_fault one cycle:
  - Next cycle duty=0, drive_en=0, state=FAULT_WAIT, retry_count=1.
  - After 4096 cycles, state=RUN with duty ramping from 0 to the stored target.
- Hold drv_fault high continuously → retry_count 1,2,3 at 4096-cycle spacing, then LOCKOUT with lockout=1.
  - cmd_valid is ignored (cmd_ready=0).
  - clear_fault → IDLE, lockout=0, target 0.
- cmd_valid and drv_fault in the same cycle in RUN → command not captured (target unchanged), fault path taken.
- reset_n low mid-ramp → all outputs zero without a clock edge.
